// File: rtl/mult_booth.sv
// mult_booth -- sequential signed WIDTH x WIDTH radix-2 Booth multiplier.
//
// A one-cycle start pulse in IDLE captures both operands. The unit then
// performs WIDTH Booth iterations, one per clock. It writes the 2*WIDTH-bit
// two's-complement product into hi/lo on the final iteration edge. It then
// raises done for exactly one cycle.
//
// Ports:
//   clock          in   rising-edge system clock
//   reset          in   asynchronous active-low reset
//   start          in   launch pulse, honoured only in IDLE
//   multiplicando  in   signed multiplicand M, sampled with start
//   multiplicador  in   signed multiplier Q, sampled with start
//   hi             out  upper WIDTH bits of the product (registered)
//   lo             out  lower WIDTH bits of the product (registered)
//   busy           out  high whenever a multiply is in progress (CALC or DONE)
//   done           out  one-cycle completion pulse (DONE state)
module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicando,
    input  logic [WIDTH-1:0] multiplicador,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // A and M carry one guard bit so that M = -2^(WIDTH-1) negates cleanly.
    logic signed [WIDTH:0] a;
    logic signed [WIDTH:0] m;
    logic signed [WIDTH:0] a_sum;
    logic signed [WIDTH:0] a_new;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      q_new;
    logic                  q_1;
    logic [CNT_W-1:0]      count;
    logic                  last;

    // Booth recode of {Q[0], Q_1}, then arithmetic right shift of {A,Q,Q_1}.
    always_comb begin
        a_sum = a;
        case ({q[0], q_1})
            2'b01:   a_sum = a + m;
            2'b10:   a_sum = a - m;
            default: a_sum = a;
        endcase
        a_new = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_new = {a_sum[0], q[WIDTH-1:1]};
        last  = (count == CNT_W'(1));
    end

    // Control: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control: next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Datapath: operand load, iteration, result write-back
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a     <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= {multiplicando[WIDTH-1], multiplicando};
                        q     <= multiplicador;
                        a     <= '0;
                        q_1   <= 1'b0;
                        count <= CNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    a     <= a_new;
                    q     <= q_new;
                    q_1   <= q[0];
                    count <= count - CNT_W'(1);
                    // The guard bit of A is pure sign extension after the
                    // last shift, so the product is {A[WIDTH-1:0], Q}.
                    if (last) begin
                        hi <= a_new[WIDTH-1:0];
                        lo <= q_new;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_booth.sv
module tb_mult_booth;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    mult_booth #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .multiplicando (mcand),
        .multiplicador (mplier),
        .hi            (hi),
        .lo            (lo),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: exact signed product using plain 64-bit arithmetic.
    function automatic logic [63:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx;
        longint sy;
        sx = $signed(x);
        sy = $signed(y);
        return 64'(sx * sy);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Launches x*y, optionally pulses a
    // second start (with operands ix, iy) at cycle intr_cyc of the run,
    // scrambles operands during CALC, and checks latency, result, hold of
    // the previous hi/lo, the single done pulse and the return to IDLE.
    task automatic run_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                           input int intr_cyc, input logic [W-1:0] ix, input logic [W-1:0] iy);
        logic [63:0]  expp;
        logic [W-1:0] ph;
        logic [W-1:0] pl;
        int           cyc;
        bit           hold_ok;
        expp   = ref_prod(x, y);
        ph     = hi;
        pl     = lo;
        mcand  = x;
        mplier = y;
        start  = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        cyc     = 1;
        hold_ok = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (hi !== ph || lo !== pl || busy !== 1'b1) hold_ok = 1'b0;
            if (intr_cyc != 0 && cyc == intr_cyc) begin
                start  = 1'b1;
                mcand  = ix;
                mplier = iy;
            end else begin
                start  = 1'b0;
                mcand  = $urandom;
                mplier = $urandom;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check("latency", 64'(cyc), 64'd33);
        check("busy_at_done", {63'd0, busy}, 64'd1);
        check("product", {hi, lo}, expp);
        check("hold_during_calc", {63'd0, hold_ok}, 64'd1);
        @(negedge clock);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        bit idle_ok;
        bit saw_done;

        reset  = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(negedge clock);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        reset = 1'b1;

        // Idle with start low: outputs stay quiet even as operands wiggle.
        idle_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mcand  = $urandom;
            mplier = $urandom;
            @(negedge clock);
            if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
        end
        check("idle_quiet", {63'd0, idle_ok}, 64'd1);

        // Directed products.
        run_mul(32'd3, 32'd5, 0, '0, '0);
        check("3x5", {hi, lo}, 64'h0000_0000_0000_000F);
        run_mul(32'hFFFF_FFF9, 32'd6, 0, '0, '0);
        check("m7x6", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        run_mul(32'h8000_0000, 32'h8000_0000, 0, '0, '0);
        check("minxmin", {hi, lo}, 64'h4000_0000_0000_0000);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, '0);
        check("m1xm1", {hi, lo}, 64'h0000_0000_0000_0001);
        run_mul(32'd0, 32'h8765_4321, 0, '0, '0);
        run_mul(32'h1234_5678, 32'd0, 0, '0, '0);

        // Restart attempt at iteration 5 is ignored; then relaunch on the
        // IDLE cycle right after done (run_mul returns at that cycle).
        run_mul(32'd10, 32'd10, 5, 32'd2, 32'd2);
        check("lo_10x10", {32'd0, lo}, 64'd100);
        run_mul(32'd2, 32'd2, 0, '0, '0);
        check("lo_2x2", {32'd0, lo}, 64'd4);

        // Randomized products, some with a stray start pulse mid-run.
        for (int i = 0; i < 10; i++) begin
            run_mul($urandom, $urandom, 0, '0, '0);
        end
        for (int i = 0; i < 4; i++) begin
            run_mul($urandom, $urandom, $urandom_range(2, 31), $urandom, $urandom);
        end
        run_mul(32'd2, 32'd2, 0, '0, '0);

        // Reset mid-calculation aborts at once.
        mcand  = 32'd123;
        mplier = 32'd456;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        check("abort_no_done", {63'd0, saw_done}, 64'd0);
        run_mul(32'd4, 32'd4, 0, '0, '0);
        check("lo_4x4", {32'd0, lo}, 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
